// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses onto a word-wide DataMemory (RMW for sub-word stores).
// Optional misalignment trap: define LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter int ADDR_WIDTH = 7,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_WriteEnable,
    output logic [31:0]           mem_WriteData,
    input  logic [31:0]           mem_MemData
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic                  misalign_err
`endif
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

    state_e                  state_q, state_d;
    logic                    write_q;
    logic [1:0]              size_q;
    logic                    uns_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             wdata_q;
    logic [31:0]             rdata_q;
    logic                    err_q;

    logic                    accept;
    logic                    mis;
    logic                    is_byte, is_half;
    logic [1:0]              a_lo, off;
    logic [4:0]              shamt;
    logic [31:0]             shifted, extracted, mask, merged;

    assign req_ready       = (state_q == IDLE);
    assign accept          = req_valid & req_ready;
    assign resp_valid      = (state_q == RESP);
    assign resp_rdata      = rdata_q;
    assign mem_WriteEnable = (state_q == WRITE);
    assign mem_WriteData   = wdata_q;
    assign mem_address     = {addr_q[ADDR_WIDTH-1:2], 2'b00};

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis = ((req_size == 2'b01) & req_addr[0]) |
                 (req_size[1] & (|req_addr[1:0]));
    assign misalign_err = err_q;
`else
    assign mis = 1'b0;
`endif

    // Lane offset of the datum's least-significant byte within the word
    assign is_byte = (size_q == 2'b00);
    assign is_half = (size_q == 2'b01);

    always_comb begin
        a_lo = 2'b00;
        off  = 2'b00;
        if (is_byte) begin
            a_lo = addr_q[1:0];
            off  = BIG_ENDIAN ? 2'd3 - a_lo : a_lo;
        end else if (is_half) begin
            a_lo = {addr_q[1], 1'b0};
            off  = BIG_ENDIAN ? 2'd2 - a_lo : a_lo;
        end
    end

    assign shamt   = {off, 3'b000};
    assign shifted = mem_MemData >> shamt;

    always_comb begin
        extracted = mem_MemData;
        mask      = 32'hFFFF_FFFF;
        if (is_byte) begin
            extracted = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            mask      = 32'h0000_00FF << shamt;
        end else if (is_half) begin
            extracted = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            mask      = 32'h0000_FFFF << shamt;
        end
        merged = (mem_MemData & ~mask) | ((wdata_q << shamt) & mask);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (mis)
                        state_d = RESP;
                    else if (req_write & req_size[1])
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            READ:    state_d = write_q ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write_q <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                write_q <= req_write;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= mis;
                if (mis)
                    rdata_q <= '0;
            end
            // wdata_q doubles as the merge buffer for sub-word stores
            if (state_q == READ) begin
                if (write_q)
                    wdata_q <= merged;
                else
                    rdata_q <= extracted;
            end
            if (state_q == WRITE)
                rdata_q <= '0;
        end
    end

endmodule
